// File: rtl/npu_pkg.sv
// Shared NPU constants, requant FSM state encoding and the signed clamp helper.
package npu_pkg;

  localparam int PSUM_W = 24;
  localparam int ACT_W  = 8;
  localparam int ACC_W  = 32;

  typedef enum logic {
    ACCUM,
    EMIT
  } state_t;

  // Clamp a wide signed value into the signed range of 'width' bits (width <= 63).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/requant_unit.sv
// Combinational requantizer: rounding arithmetic shift, optional ReLU, clamp to OUT_W.
module requant_unit #(
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int OUT_W = npu_pkg::ACT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  input  logic                    relu,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);
  import npu_pkg::*;

  logic signed [63:0] wide;
  logic signed [63:0] rounded;
  logic signed [63:0] r;
  logic signed [63:0] clamped;

  // The rounding add saturates at ACC_W but does not raise sat; only the final clamp does.
  always_comb begin
    wide    = 64'(acc);
    rounded = sat_clamp(wide + (64'sd1 <<< (shift - 5'd1)), ACC_W);
    r       = (shift == 5'd0) ? wide : (rounded >>> shift);
    if (relu && (r < 0)) r = '0;
    clamped = sat_clamp(r, OUT_W);
    sat     = (clamped != r);
    data    = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_requant.sv
// Partial-sum accumulator and requantizer between PE column output and activation buffer.
// Optional saturation statistics counter enabled by defining PSUM_REQUANT_STATS_EN.
module psum_requant #(
  parameter int PSUM_W = npu_pkg::PSUM_W,
  parameter int ACC_W  = npu_pkg::ACC_W,
  parameter int OUT_W  = npu_pkg::ACT_W,
  parameter int PASS_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic        [PASS_W-1:0] cfg_passes,
  input  logic        [4:0]        cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PSUM_W-1:0] in_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic        [15:0]       sat_count
);
  import npu_pkg::*;

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic        [PASS_W-1:0]  cnt, cnt_next;
  logic        [PASS_W-1:0]  passes_lat, passes_eff;
  logic        [4:0]         shift_lat, shift_eff;
  logic                      relu_lat, relu_eff;
  logic                      acc_sat, sticky_next;
  logic                      accept, first, done;
  logic signed [63:0]        sum_wide, sum_clamped;
  logic signed [OUT_W-1:0]   rq_data;
  logic                      rq_sat;

  // The first accept of a group uses live config and a zero base; later ones use the shadow copy.
  always_comb begin
    first      = (cnt == '0);
    passes_eff = passes_lat;
    shift_eff  = shift_lat;
    relu_eff   = relu_lat;
    if (first) begin
      passes_eff = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
      shift_eff  = cfg_shift;
      relu_eff   = cfg_relu;
    end
    sum_wide    = (first ? 64'sd0 : 64'(acc)) + 64'(in_psum);
    sum_clamped = sat_clamp(sum_wide, ACC_W);
    acc_next    = sum_clamped[ACC_W-1:0];
    sticky_next = (first ? 1'b0 : acc_sat) | (sum_clamped != sum_wide);
    cnt_next    = cnt + PASS_W'(1);
    done        = (cnt_next == passes_eff);
  end

  requant_unit #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_requant (
    .acc  (acc_next),
    .shift(shift_eff),
    .relu (relu_eff),
    .data (rq_data),
    .sat  (rq_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && done) state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      passes_lat <= '0;
      shift_lat  <= '0;
      relu_lat   <= 1'b0;
      acc_sat    <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (accept) begin
        acc        <= acc_next;
        acc_sat    <= sticky_next;
        cnt        <= cnt_next;
        passes_lat <= passes_eff;
        shift_lat  <= shift_eff;
        relu_lat   <= relu_eff;
        if (done) begin
          out_data <= rq_data;
          out_sat  <= rq_sat | sticky_next;
        end
      end
      if ((state == EMIT) && out_ready) cnt <= '0;
    end
  end

`ifdef PSUM_REQUANT_STATS_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if ((state == EMIT) && out_ready && out_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule
